// File: rtl/note_sequencer_if.sv
// note_sequencer_if: request, note-memory and tone-generator signals of the note sequencer.
interface note_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int NOTE_W = 5
);
  logic              rec_req;
  logic [NOTE_W-1:0] note_in;
  logic              play_req;
  logic              stop_req;
  logic              clear_req;
  logic              loop_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NOTE_W-1:0] mem_wdata;
  logic [NOTE_W-1:0] mem_rdata;
  logic              tone_valid;
  logic [NOTE_W-1:0] tone_code;
  logic              busy;
  logic [ADDR_W:0]   note_count;
  modport master (
    output rec_req, note_in, play_req, stop_req, clear_req, loop_en, mem_rdata,
    input  mem_we, mem_addr, mem_wdata, tone_valid, tone_code, busy, note_count
  );
  modport slave (
    input  rec_req, note_in, play_req, stop_req, clear_req, loop_en, mem_rdata,
    output mem_we, mem_addr, mem_wdata, tone_valid, tone_code, busy, note_count
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: records key presses into a single-port note RAM and plays them back at a fixed tempo.
module note_sequencer #(
  parameter int TICKS_PER_NOTE = 25000000,
  parameter int ADDR_W         = 4,
  parameter int NOTE_W         = 5
) (
  input logic            clk,
  input logic            reset,
  note_sequencer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(TICKS_PER_NOTE);
  typedef enum logic [2:0] {IDLE, REC_WR, PLAY_FETCH, PLAY_WAIT, PLAY_HOLD} state_t;
  state_t            state, nxt;
  logic [ADDR_W:0]   note_count, count_n;
  logic [ADDR_W-1:0] play_ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NOTE_W-1:0] code_q, code_n, note_lat, lat_n;
  logic              full, last, playing;
  assign full    = note_count == (ADDR_W+1)'(DEPTH);
  assign last    = ({1'b0, play_ptr} + 1'b1) >= note_count;
  assign playing = state inside {PLAY_FETCH, PLAY_WAIT, PLAY_HOLD};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      note_count <= '0;
      play_ptr   <= '0;
      cnt        <= '0;
      code_q     <= '0;
      note_lat   <= '0;
    end else begin
      state      <= nxt;
      note_count <= count_n;
      play_ptr   <= ptr_n;
      cnt        <= cnt_n;
      code_q     <= code_n;
      note_lat   <= lat_n;
    end
  end
  always_comb begin
    nxt     = state;
    count_n = note_count;
    ptr_n   = play_ptr;
    cnt_n   = cnt;
    code_n  = code_q;
    lat_n   = note_lat;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          count_n = '0;
        end else if (bus.rec_req && !full) begin
          nxt   = REC_WR;
          lat_n = bus.note_in;
        end else if (bus.play_req && note_count != '0) begin
          nxt   = PLAY_FETCH;
          ptr_n = '0;
        end
      end
      REC_WR: begin
        count_n = note_count + 1'b1;
        nxt     = IDLE;
      end
      PLAY_FETCH: nxt = PLAY_WAIT;
      PLAY_WAIT: begin
        code_n = bus.mem_rdata;
        cnt_n  = CNT_W'(TICKS_PER_NOTE - 1);
        nxt    = PLAY_HOLD;
      end
      PLAY_HOLD: begin
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        // loop_en only matters here, at the boundary after the last note
        if (cnt == '0) begin
          nxt    = (last && !bus.loop_en) ? IDLE : PLAY_FETCH;
          ptr_n  = last ? '0 : play_ptr + 1'b1;
          code_n = (last && !bus.loop_en) ? '0 : code_q;
        end
      end
      default: nxt = IDLE;
    endcase
    if (bus.stop_req && playing) begin
      nxt    = IDLE;
      code_n = '0;
      ptr_n  = '0;
    end
  end
  assign bus.busy       = state != IDLE;
  assign bus.mem_we     = state == REC_WR;
  assign bus.mem_addr   = state == REC_WR ? note_count[ADDR_W-1:0] : state == PLAY_FETCH ? play_ptr : '0;
  assign bus.mem_wdata  = state == REC_WR ? note_lat : '0;
  assign bus.tone_valid = state == PLAY_HOLD && code_q != '0;
  assign bus.tone_code  = code_q;
  assign bus.note_count = note_count;
endmodule
